// File: rtl/power_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : power_monitor
// Purpose  : Scans 8 voltage-mux channels, majority-votes a synchronized
//            rail-good line per channel and raises a sticky fault.
// Options  : define PM_AUTOKILL_EN to drive kill from a registered fault.
// Revision : 1.0
// ---------------------------------------------------------------------------
module power_monitor #(
  parameter int SETTLE_CYCLES = 50000,
  parameter int SAMPLES       = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       enable,
  input  logic       status_in,
  input  logic [7:0] chan_mask,
  input  logic       clear_fault,
  output logic [2:0] mux_sel,
  output logic       kill,
  output logic [7:0] good_map,
  output logic       fault,
  output logic       busy,
  output logic       scan_done
);

  localparam int CNT_W  = 20;
  localparam int ONES_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ONES_W:0]  MAJ_THRESH  = (ONES_W + 1)'(SAMPLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [2:0]        chan_q, chan_d;
  logic [7:0]        good_q, good_d;
  logic              fault_q, fault_d;
  logic              done_q, done_d;
  logic              sync1_q, sync2_q;
  logic              chan_good;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= status_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      chan_q  <= '0;
      good_q  <= '0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      chan_q  <= chan_d;
      good_q  <= good_d;
      fault_q <= fault_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    chan_d    = chan_q;
    good_d    = good_q;
    fault_d   = fault_q;
    done_d    = 1'b0;
    // Strict majority: a tie counts as bad.
    chan_good = {ones_q, 1'b0} > MAJ_THRESH;

    if (clear_fault) fault_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          chan_d  = '0;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        ones_d = ones_q + ONES_W'(sync2_q);
        if (cnt_q == SAMPLE_LAST) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        good_d[chan_q] = chan_good;
        // A set in the same cycle as clear_fault overrides the clear above.
        if (!chan_good && !chan_mask[chan_q]) fault_d = 1'b1;
        ones_d = '0;
        cnt_d  = '0;
        if (chan_q == 3'd7) begin
          done_d  = 1'b1;
          chan_d  = '0;
          state_d = enable ? SETTLE : IDLE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PM_AUTOKILL_EN
  logic kill_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) kill_q <= 1'b0;
    else       kill_q <= fault_q;
  end

  assign kill = kill_q;
`else
  assign kill = 1'b0;
`endif

  assign mux_sel   = chan_q;
  assign good_map  = good_q;
  assign fault     = fault_q;
  assign busy      = (state_q != IDLE);
  assign scan_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_power_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_power_monitor
// Purpose  : Directed self-checking bench for power_monitor (SETTLE=4,
//            SAMPLES=4, 9 cycles per channel, 72 per scan).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_power_monitor;

`ifdef PM_AUTOKILL_EN
  localparam logic AK = 1'b1;
`else
  localparam logic AK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0;
  logic       status_in = 1'b0;
  logic [7:0] chan_mask = 8'h00;
  logic       clear_fault = 1'b0;
  logic [2:0] mux_sel;
  logic       kill;
  logic [7:0] good_map;
  logic       fault;
  logic       busy;
  logic       scan_done;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;  // 0: status always 1, 1: status 0 while mux_sel == 5

  power_monitor #(
    .SETTLE_CYCLES(4),
    .SAMPLES      (4)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (RESET),
    .enable     (enable),
    .status_in  (status_in),
    .chan_mask  (chan_mask),
    .clear_fault(clear_fault),
    .mux_sel    (mux_sel),
    .kill       (kill),
    .good_map   (good_map),
    .fault      (fault),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and drive status from the current mode.
  task automatic step();
    @(negedge clk);
    status_in = (mode == 1) ? (mux_sel != 3'd5) : 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1; enable = 1'b0; clear_fault = 1'b0;
    status_in = 1'b0; chan_mask = 8'h00;
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (mux_sel !== 3'd0) begin n_err++; $display("FAIL rst_mux_sel: got %0d expected 0", mux_sel); end
    n_vec++; if (good_map !== 8'h00) begin n_err++; $display("FAIL rst_good_map: got %h expected 00", good_map); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b expected 0", fault); end
    n_vec++; if (kill !== 1'b0) begin n_err++; $display("FAIL rst_kill: got %b expected 0", kill); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL rst_scan_done: got %b expected 0", scan_done); end
  endtask

  task automatic test_reset_mid_sample();
    do_reset();
    mode = 0; enable = 1'b1; status_in = 1'b1;
    repeat (33) step();
    n_vec++; if (mux_sel !== 3'd3) begin n_err++; $display("FAIL mid_mux_sel: got %0d expected 3", mux_sel); end
    n_vec++; if (good_map !== 8'h07) begin n_err++; $display("FAIL mid_good_map: got %h expected 07", good_map); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", busy); end
    RESET = 1'b1;
    step();
    n_vec++; if (mux_sel !== 3'd0) begin n_err++; $display("FAIL abort_mux_sel: got %0d expected 0", mux_sel); end
    n_vec++; if (good_map !== 8'h00) begin n_err++; $display("FAIL abort_good_map: got %h expected 00", good_map); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL abort_fault: got %b expected 0", fault); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    RESET = 1'b0;
  endtask

  task automatic test_full_scan_good();
    do_reset();
    mode = 0; enable = 1'b1; status_in = 1'b1;
    repeat (72) step();
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL early_scan_done: got %b expected 0", scan_done); end
    n_vec++; if (good_map !== 8'h7F) begin n_err++; $display("FAIL pre_done_good_map: got %h expected 7f", good_map); end
    step();
    n_vec++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL scan_done_pulse: got %b expected 1", scan_done); end
    n_vec++; if (good_map !== 8'hFF) begin n_err++; $display("FAIL all_good_map: got %h expected ff", good_map); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL all_good_fault: got %b expected 0", fault); end
    n_vec++; if (busy !== 1'b1 || mux_sel !== 3'd0) begin n_err++; $display("FAIL restart: got busy=%b mux=%0d expected busy=1 mux=0", busy, mux_sel); end
    step();
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL scan_done_width: got %b expected 0", scan_done); end
  endtask

  task automatic test_bad_channel(input logic [7:0] mask, input logic exp_fault);
    do_reset();
    mode = 1; chan_mask = mask; enable = 1'b1; status_in = 1'b1;
    step();
    enable = 1'b0;
    repeat (53) step();
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL pre_eval_fault[%h]: got %b expected 0", mask, fault); end
    step();
    n_vec++; if (fault !== exp_fault) begin n_err++; $display("FAIL eval_fault[%h]: got %b expected %b", mask, fault, exp_fault); end
    n_vec++; if (kill !== 1'b0) begin n_err++; $display("FAIL kill_lag[%h]: got %b expected 0", mask, kill); end
    step();
    n_vec++; if (kill !== (exp_fault & AK)) begin n_err++; $display("FAIL kill[%h]: got %b expected %b", mask, kill, exp_fault & AK); end
    repeat (17) step();
    n_vec++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL bad_scan_done[%h]: got %b expected 1", mask, scan_done); end
    n_vec++; if (good_map !== 8'hDF) begin n_err++; $display("FAIL bad_good_map[%h]: got %h expected df", mask, good_map); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy[%h]: got %b expected 0", mask, busy); end
    repeat (3) step();
    n_vec++; if (good_map !== 8'hDF || busy !== 1'b0) begin n_err++; $display("FAIL idle_hold[%h]: got map=%h busy=%b expected map=df busy=0", mask, good_map, busy); end
    n_vec++; if (fault !== exp_fault) begin n_err++; $display("FAIL sticky_fault[%h]: got %b expected %b", mask, fault, exp_fault); end
  endtask

  // pat bit i is driven on the falling edge after the i-th clock of the scan;
  // bits 2..5 are the four values that reach channel 0's samples.
  task automatic test_majority(input logic [8:0] pat, input logic exp_good);
    do_reset();
    enable = 1'b1; status_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      status_in = pat[i];
      enable = 1'b0;
    end
    @(negedge clk);
    n_vec++; if (good_map[0] !== exp_good) begin n_err++; $display("FAIL majority[%b]: got %b expected %b", pat, good_map[0], exp_good); end
  endtask

  task automatic test_clear_vs_set();
    do_reset();
    mode = 1; enable = 1'b1; status_in = 1'b1;
    step();
    enable = 1'b0;
    repeat (53) step();
    clear_fault = 1'b1;
    step();
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b expected 1", fault); end
    step();
    clear_fault = 1'b0;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL clear_fault: got %b expected 0", fault); end
    n_vec++; if (kill !== AK) begin n_err++; $display("FAIL kill_follow: got %b expected %b", kill, AK); end
    step();
    n_vec++; if (kill !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL kill_release: got kill=%b fault=%b expected 0 0", kill, fault); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sample();
    test_full_scan_good();
    test_bad_channel(8'h00, 1'b1);
    test_bad_channel(8'h20, 1'b0);
    test_majority(9'b000001100, 1'b0);
    test_majority(9'b000011100, 1'b1);
    test_majority(9'b000111100, 1'b1);
    test_clear_vs_set();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
